// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: borrows the Z80 memory bus for a DMA master using
// BUSRQ/BUSAK, with a per-grant burst limit, hold-off and ack timeout.
module z80_bus_arbiter #(
  parameter int BURST_MAX   = 16,
  parameter int HOLDOFF     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_busak_n,
  output logic        cpu_busrq_n,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        owner,
  output logic        timeout_err
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam int TW = $clog2(ACK_TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_CPU,
    S_REQ,
    S_DMA,
    S_REL,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_burst;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_tmo;
  logic          r_ack;
  logic          r_err;

  logic w_owner;
  logic w_full;
  logic w_hold_done;
  logic w_tmo_done;
  logic w_accept;

  assign w_owner     = (r_state == S_DMA);
  assign w_full      = (r_burst == BW'(BURST_MAX));
  assign w_hold_done = (int'(r_hold) + 1 >= HOLDOFF);
  assign w_tmo_done  = (int'(r_tmo) + 1 >= ACK_TIMEOUT);
  assign w_accept    = w_owner && dma_req
                    && !cpu_busak_n && !w_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CPU;
    end else begin
      r_state <= w_next;
    end
  end

  // A lost BUSAK inside DMA wins over every other exit.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CPU: begin
        if (dma_req) w_next = S_REQ;
      end
      S_REQ: begin
        if (!cpu_busak_n) w_next = S_DMA;
        else if (w_tmo_done) w_next = S_HOLD;
      end
      S_DMA: begin
        if (cpu_busak_n) w_next = S_CPU;
        else if (w_full || !dma_req) w_next = S_REL;
      end
      S_REL: begin
        if (cpu_busak_n) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_hold_done) w_next = S_CPU;
      end
      default: w_next = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_burst <= '0;
      r_hold  <= '0;
      r_tmo   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_burst <= (r_state != S_DMA) ? '0
               : r_burst + BW'(w_accept);
      if (r_state != S_HOLD) r_hold <= '0;
      else if (r_hold != '1) r_hold <= r_hold + HW'(1);
      if (r_state != S_REQ) r_tmo <= '0;
      else if (r_tmo != '1) r_tmo <= r_tmo + TW'(1);
      r_ack <= w_accept;
      if (r_state == S_REQ && w_next == S_HOLD) r_err <= 1'b1;
    end
  end

  assign cpu_busrq_n = !(r_state == S_REQ || r_state == S_DMA);
  assign owner       = w_owner;
  assign timeout_err = r_err;
  assign dma_ack     = r_ack;
  // Memory answers one cycle after the address: that is the ack cycle.
  assign dma_rdata   = r_ack ? mem_rdata : 8'h00;

  assign mem_addr  = w_owner ? dma_addr : cpu_a;
  assign mem_wdata = w_owner ? dma_wdata : cpu_do;
  assign mem_we    = w_owner ? (dma_we && w_accept)
                   : (!cpu_mreq_n && !cpu_wr_n);

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb_z80_bus_arbiter: CPU-side mux vector table plus scripted DMA
// sequences scored against a queue of accepted transfers.
module tb_z80_bus_arbiter;

  localparam int BURST = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n;
  logic        cpu_wr_n;
  logic        cpu_busak_n;
  logic        cpu_busrq_n;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        owner;
  logic        timeout_err;

  z80_bus_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_a       (cpu_a),
    .cpu_do      (cpu_do),
    .cpu_mreq_n  (cpu_mreq_n),
    .cpu_wr_n    (cpu_wr_n),
    .cpu_busak_n (cpu_busak_n),
    .cpu_busrq_n (cpu_busrq_n),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_ack     (dma_ack),
    .dma_rdata   (dma_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  logic [7:0] tbmem [0:65535];
  always @(posedge clk) begin
    if (mem_we) tbmem[mem_addr] <= mem_wdata;
    mem_rdata <= tbmem[mem_addr];
  end

  // CPU model: BUSAK follows BUSRQ three cycles late.
  logic [2:0] r_bk = 3'b111;
  logic       busak_hold = 1'b0;
  always @(posedge clk) r_bk <= {r_bk[1:0], cpu_busrq_n};
  assign cpu_busak_n = r_bk[2] | busak_hold;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        mreq_n;
    logic        wr_n;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wdata;
  } vec_t;

  sb_t  sb [$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_acc = 1'b0;
  logic last_acc = 1'b0;
  int   gcnt = 0;
  int   n_ack, ack_run, max_run, last_run, hi_run, last_gap;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_stats();
    n_ack = 0; ack_run = 0; max_run = 0;
    last_run = 0; hi_run = 0; last_gap = 0;
  endtask

  // One clock: check at negedge, then return 1 time unit past posedge.
  task automatic tick();
    logic acc;
    sb_t  e;
    @(negedge clk);
    acc = owner && !cpu_busak_n && dma_req && (gcnt < BURST);
    chk("ack_timing", dma_ack, prev_acc);
    if (dma_ack) begin
      n_ack++;
      ack_run++;
      chk("sb_has_entry", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.we) chk("dma_rdata", dma_rdata, e.data);
      end
    end else if (ack_run > 0) begin
      last_run = ack_run;
      if (ack_run > max_run) max_run = ack_run;
      ack_run = 0;
    end
    if (owner) begin
      chk("dma_busrq", cpu_busrq_n, 1'b0);
      chk("dma_mem_addr", mem_addr, dma_addr);
      chk("dma_mem_we", mem_we, acc && dma_we);
      if (mem_we) chk("dma_mem_wdata", mem_wdata, dma_wdata);
    end else begin
      chk("cpu_mem_addr", mem_addr, cpu_a);
      chk("cpu_mem_we", mem_we, !cpu_mreq_n && !cpu_wr_n);
      chk("cpu_mem_wdata", mem_wdata, cpu_do);
    end
    if (cpu_busrq_n) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
    if (acc) begin
      e.we   = dma_we;
      e.addr = dma_addr;
      e.data = dma_we ? dma_wdata : tbmem[dma_addr];
      sb.push_back(e);
      gcnt++;
    end
    if (!owner) gcnt = 0;
    prev_acc = acc;
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dma_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic dma_burst(input logic [15:0] base, input int n,
                           input logic we, input logic [7:0] wd0);
    int i = 0;
    int c = 0;
    while (i < n && c < 300) begin
      dma_req   = 1'b1;
      dma_we    = we;
      dma_addr  = base + 16'(i);
      dma_wdata = wd0 + 8'(i * 37);
      tick();
      if (last_acc) i++;
      c++;
    end
    dma_req = 1'b0;
    chk("burst_done", i, n);
  endtask

  vec_t vt [5];
  int   cnt;
  int   c;
  logic early;
  logic [7:0] old;

  initial begin
    vt[0] = '{16'h1234, 8'h55, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h55};
    vt[1] = '{16'h0002, 8'hAB, 1'b0, 1'b0, 16'h0002, 1'b1, 8'hAB};
    vt[2] = '{16'hFFFF, 8'h01, 1'b1, 1'b0, 16'hFFFF, 1'b0, 8'h01};
    vt[3] = '{16'h8000, 8'hC3, 1'b1, 1'b1, 16'h8000, 1'b0, 8'hC3};
    vt[4] = '{16'h00F0, 8'h3C, 1'b0, 1'b0, 16'h00F0, 1'b1, 8'h3C};

    reset_n = 1'b0;
    cpu_a = '0; cpu_do = '0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    #1;
    chk("rst_busrq", cpu_busrq_n, 1'b1);
    chk("rst_owner", owner, 1'b0);
    chk("rst_ack", dma_ack, 1'b0);
    chk("rst_rdata", dma_rdata, 8'h00);
    chk("rst_err", timeout_err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clr_stats();

    for (int k = 0; k < 5; k++) begin
      cpu_a = vt[k].a; cpu_do = vt[k].d;
      cpu_mreq_n = vt[k].mreq_n; cpu_wr_n = vt[k].wr_n;
      @(negedge clk);
      chk("vec_addr", mem_addr, vt[k].e_addr);
      chk("vec_we", mem_we, vt[k].e_we);
      chk("vec_wdata", mem_wdata, vt[k].e_wdata);
      chk("vec_owner", owner, 1'b0);
      chk("vec_busrq", cpu_busrq_n, 1'b1);
      @(posedge clk);
      #1;
    end
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    chk("cpu_wr_0002", tbmem[16'h0002], 8'hAB);
    chk("cpu_wr_00F0", tbmem[16'h00F0], 8'h3C);

    for (int k = 0; k < 20; k++) begin
      cpu_a = 16'(k); cpu_do = 8'hA0 ^ 8'(k * 13);
      cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
      tick();
    end
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    chk("preload_13", tbmem[16'h0013], 8'hA0 ^ 8'(19 * 13));

    clr_stats();
    dma_burst(16'h16CF, 1, 1'b1, 8'h7B);
    tick();
    dma_burst(16'h2000, 1, 1'b1, 8'h11);
    idle(12);
    chk("wr_mem", tbmem[16'h16CF], 8'h7B);
    chk("wr_mem2", tbmem[16'h2000], 8'h11);
    chk("wr_acks", n_ack, 2);
    chk("wr_rel_hold_gap", last_gap, 9);

    clr_stats();
    dma_burst(16'h0000, 20, 1'b0, 8'h00);
    idle(15);
    chk("rd_acks", n_ack, 20);
    chk("rd_first_run", max_run, 16);
    chk("rd_second_run", last_run, 4);
    chk("rd_regrant_gap", last_gap, 9);
    chk("rd_sb_empty", sb.size(), 0);

    clr_stats();
    dma_burst(16'h3000, 5, 1'b1, 8'h40);
    chk("drop_owner", owner, 1'b1);
    tick();
    chk("drop_rel_owner", owner, 1'b0);
    chk("drop_rel_busrq", cpu_busrq_n, 1'b1);
    idle(12);
    chk("drop_acks", n_ack, 5);
    chk("drop_mem", tbmem[16'h3004], 8'hD4);

    clr_stats();
    dma_burst(16'h4000, 3, 1'b1, 8'h90);
    dma_req = 1'b1; dma_addr = 16'h4003; dma_wdata = 8'h5E;
    busak_hold = 1'b1;
    tick();
    busak_hold = 1'b0;
    chk("abort_owner", owner, 1'b0);
    chk("abort_busrq", cpu_busrq_n, 1'b1);
    dma_burst(16'h4003, 2, 1'b1, 8'hA5);
    idle(20);
    chk("abort_acks", n_ack, 5);
    chk("abort_mem3", tbmem[16'h4003], 8'hA5);
    chk("abort_mem4", tbmem[16'h4004], 8'hCA);

    clr_stats();
    dma_burst(16'h5000, 3, 1'b1, 8'h20);
    old = tbmem[16'h5003];
    dma_req = 1'b1; dma_addr = 16'h5003; dma_wdata = 8'hEE;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busrq", cpu_busrq_n, 1'b1);
    chk("mid_rst_owner", owner, 1'b0);
    chk("mid_rst_ack", dma_ack, 1'b0);
    chk("mid_rst_we", mem_we, 1'b0);
    prev_acc = 1'b0; gcnt = 0; sb.delete();
    tick();
    dma_req = 1'b0;
    tick();
    reset_n = 1'b1;
    idle(6);
    chk("mid_rst_nowrite", tbmem[16'h5003], old);
    chk("mid_rst_mem2", tbmem[16'h5002], 8'h6A);
    dma_req = 1'b1; dma_we = 1'b1;
    dma_addr = 16'h6000; dma_wdata = 8'h66;
    tick();
    chk("no_hold_after_rst", cpu_busrq_n, 1'b0);
    dma_burst(16'h6000, 1, 1'b1, 8'h66);
    idle(12);
    chk("post_rst_mem", tbmem[16'h6000], 8'h66);

    clr_stats();
    busak_hold = 1'b1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h7000;
    cnt = 0; c = 0; early = 1'b0;
    while (c < 600) begin
      tick();
      c++;
      if (!cpu_busrq_n) begin
        cnt++;
        if (timeout_err) early = 1'b1;
      end else if (cnt > 0) begin
        break;
      end
    end
    chk("tmo_req_cycles", cnt, 255);
    chk("tmo_err_set", timeout_err, 1'b1);
    chk("tmo_err_early", early, 1'b0);
    idle(10);
    busak_hold = 1'b0;
    idle(4);
    chk("tmo_err_sticky", timeout_err, 1'b1);
    dma_burst(16'h7000, 1, 1'b1, 8'h77);
    idle(12);
    chk("tmo_err_sticky2", timeout_err, 1'b1);
    chk("tmo_then_wr", tbmem[16'h7000], 8'h77);
    reset_n = 1'b0;
    #1;
    chk("tmo_err_cleared", timeout_err, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
